// File: rtl/io_unit_pkg.sv
// Shared definitions for the I/O unit: register addresses, status bit
// positions and the UART state encodings.
package io_unit_pkg;

  // Word addresses within the I/O page
  localparam logic [5:0] IO_TIMER = 6'd0;
  localparam logic [5:0] IO_SWI   = 6'd1;
  localparam logic [5:0] IO_UDATA = 6'd2;
  localparam logic [5:0] IO_USTAT = 6'd3;

  // Bit positions in the UART status word
  localparam int ST_RX_RDY = 0;
  localparam int ST_TX_RDY = 1;
  localparam int ST_RX_OVR = 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BITS
  } tx_state_t;

  // Assemble the status word; all bits above the flags read as zero.
  function automatic logic [31:0] status_word(input logic rx_rdy,
                                              input logic tx_rdy,
                                              input logic rx_ovr);
    logic [31:0] w;
    w            = '0;
    w[ST_RX_RDY] = rx_rdy;
    w[ST_TX_RDY] = tx_rdy;
    w[ST_RX_OVR] = rx_ovr;
    return w;
  endfunction

endpackage

// File: rtl/io_unit_if.sv
// CPU-side I/O bus: word address, read/write strobes and the two data buses.
interface io_unit_if;
  logic [5:0]  ioadr;
  logic        iord;
  logic        iowr;
  logic [31:0] outbus;
  logic [31:0] inbus;

  modport master (output ioadr, output iord, output iowr, output outbus,
                  input inbus);
  modport slave  (input ioadr, input iord, input iowr, input outbus,
                  output inbus);
endinterface

// File: rtl/io_unit_uart_rx.sv
// UART receiver, 8N1. The line is synchronised, the start bit is re-checked
// at half a bit time to reject glitches, and each following bit is sampled
// one full bit time later, i.e. at mid-bit. done pulses for one clock when
// a frame with a valid stop bit completes; data then holds the byte.
module uart_rx
  import io_unit_pkg::*;
#(
  parameter int BIT_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       done,
  output logic [7:0] data
);

  localparam int HALF = (BIT_DIV / 2 > 0) ? BIT_DIV / 2 : 1;
  localparam int CW   = $clog2(BIT_DIV + 1);

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxd_s;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          half_hit;
  logic          bit_hit;

  assign rxd_s    = sync_q[1];
  assign half_hit = (cnt_q == CW'(HALF - 1));
  assign bit_hit  = (cnt_q == CW'(BIT_DIV - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (!rxd_s) state_d = RX_START;
      RX_START: if (half_hit) state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && idx_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_hit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Line synchroniser, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done    <= 1'b0;
      data    <= '0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      done   <= 1'b0;

      if (state_q == RX_IDLE || (state_q == RX_START && half_hit) || bit_hit)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);

      if (state_q == RX_START)
        idx_q <= '0;
      else if (state_q == RX_DATA && bit_hit)
        idx_q <= idx_q + 3'd1;

      if (state_q == RX_DATA && bit_hit)
        shift_q <= {rxd_s, shift_q[7:1]};

      // A low stop bit is a framing error: the byte is dropped silently.
      if (state_q == RX_STOP && bit_hit && rxd_s) begin
        done <= 1'b1;
        data <= shift_q;
      end
    end
  end

endmodule

// File: rtl/io_unit.sv
// Memory-mapped I/O page: millisecond timer, switches/LEDs and a UART.
// Read data is combinational from the address; read side effects fire only
// on the first cycle of a (possibly stretched) read strobe.
module io_unit
  import io_unit_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 19200
) (
  input  logic       clk,
  input  logic       rst,
  io_unit_if.slave   bus,
  input  logic [7:0] swi,
  output logic [7:0] leds,
  input  logic       rxd,
  output logic       txd
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int MS_DIV  = CLK_HZ / 1000;
  localparam int TXW     = $clog2(BIT_DIV + 1);

  logic [31:0]    timer;
  logic [31:0]    ms_cnt;
  logic           ms_tick;
  logic [7:0]     swi_meta;
  logic [7:0]     swi_sync;
  logic           iord_q;
  logic           rd_first;
  logic           rd_data;
  logic           rd_stat;
  logic           rx_done;
  logic [7:0]     rx_data;
  logic [7:0]     rx_buf;
  logic           rx_rdy;
  logic           rx_ovr;
  tx_state_t      tx_state_q, tx_state_d;
  logic [TXW-1:0] tx_cnt;
  logic [3:0]     tx_bitn;
  logic [9:0]     tx_sh;
  logic           tx_rdy;
  logic           tx_load;
  logic           tx_bit_end;
  logic           tx_last;
  logic           unused_ok;

  // Only the low byte of a store is meaningful to any register here.
  assign unused_ok = &{1'b0, bus.outbus[31:8]};

  assign ms_tick    = (ms_cnt == 32'(MS_DIV - 1));
  assign rd_first   = bus.iord & ~iord_q;
  assign rd_data    = rd_first && (bus.ioadr == IO_UDATA);
  assign rd_stat    = rd_first && (bus.ioadr == IO_USTAT);
  assign tx_rdy     = (tx_state_q == TX_IDLE);
  assign tx_load    = bus.iowr && (bus.ioadr == IO_UDATA) && tx_rdy;
  assign tx_bit_end = (tx_cnt == TXW'(BIT_DIV - 1));
  assign tx_last    = tx_bit_end && (tx_bitn == 4'd9);
  assign txd        = tx_sh[0];

  uart_rx #(.BIT_DIV(BIT_DIV)) u_rx (
    .clk  (clk),
    .rst  (rst),
    .rxd  (rxd),
    .done (rx_done),
    .data (rx_data)
  );

  // Millisecond prescaler and free-running timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt <= '0;
      timer  <= '0;
    end else begin
      ms_cnt <= ms_tick ? '0 : ms_cnt + 32'd1;
      if (ms_tick) timer <= timer + 32'd1;
    end
  end

  // Switch synchroniser, LED register and read-strobe edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swi_meta <= '0;
      swi_sync <= '0;
      leds     <= '0;
      iord_q   <= 1'b0;
    end else begin
      swi_meta <= swi;
      swi_sync <= swi_meta;
      iord_q   <= bus.iord;
      if (bus.iowr && bus.ioadr == IO_SWI) leds <= bus.outbus[7:0];
    end
  end

  // Receive buffer and flags; a completing byte takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf <= '0;
      rx_rdy <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_buf <= rx_data;
        rx_rdy <= 1'b1;
      end else if (rd_data) begin
        rx_rdy <= 1'b0;
      end

      if (rx_done && rx_rdy) rx_ovr <= 1'b1;
      else if (rd_stat)      rx_ovr <= 1'b0;
    end
  end

  // Transmitter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= TX_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  // Transmitter next state: a store starts a frame, the stop bit ends it.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (tx_load) tx_state_d = TX_BITS;
      TX_BITS: if (tx_last) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Transmit shift register; bit 0 drives the line and ones fill behind,
  // so the line is left idle-high once the frame has shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bitn <= '0;
    end else if (tx_load) begin
      tx_sh   <= {1'b1, bus.outbus[7:0], 1'b0};
      tx_cnt  <= '0;
      tx_bitn <= '0;
    end else if (tx_state_q == TX_BITS) begin
      if (tx_bit_end) begin
        tx_cnt  <= '0;
        tx_bitn <= tx_bitn + 4'd1;
        tx_sh   <= {1'b1, tx_sh[9:1]};
      end else begin
        tx_cnt  <= tx_cnt + TXW'(1);
      end
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    bus.inbus = '0;
    case (bus.ioadr)
      IO_TIMER: bus.inbus = timer;
      IO_SWI:   bus.inbus = {24'b0, swi_sync};
      IO_UDATA: bus.inbus = {24'b0, rx_buf};
      IO_USTAT: bus.inbus = status_word(rx_rdy, tx_rdy, rx_ovr);
      default:  bus.inbus = '0;
    endcase
  end

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 19200, UART bit rate; BIT_DIV = CLK_HZ/BAUD (integer, truncated).
REQ-003 Ports: clk  in  1  sole clock, all state updates on posedge.
REQ-004 Ports: rst  in  1  asynchronous, active-high reset.
REQ-005 Ports: ioadr  in  6  word address within the I/O page, from the CPU.
REQ-006 Ports: iord  in  1  CPU I/O read strobe; may stay high for 2 consecutive cycles for one load.
REQ-007 Ports: iowr  in  1  CPU I/O write strobe, one cycle per store.
REQ-008 Ports: outbus  in  32  CPU write data.
REQ-009 Ports: inbus  out  32  read data to the CPU.
REQ-010 Ports: swi  in  8  board switches, asynchronous.
REQ-011 Ports: leds  out  8  LED register.
REQ-012 Ports: rxd  in  1  UART receive line, asynchronous, idle high.
REQ-013 Ports: txd  out  1  UART transmit line, idle high.

Function
REQ-014 Address map: 0 ms timer (R); 1 switches (R) / LEDs (W); 2 UART data (R rx byte / W tx byte); 3 UART status (R); other addresses read 0, writes ignored.
REQ-015 inbus shall be combinational from ioadr and current register state, independent of iord.
REQ-016 Timer: 32-bit count incremented once per CLK_HZ/1000 clocks; wraps 0xFFFFFFFF -> 0; writes ignored.
REQ-017 Address 1 read: {24'b0, swi} after a 2-flop synchronizer; write: leds <= outbus[7:0] on the iowr cycle.
REQ-018 Status word: bit0 rx_rdy, bit1 tx_rdy, bit2 rx_ovr, bits 31:3 zero.
REQ-019 Read side effects trigger on the first iord cycle only (iord & ~iord_q), never on the second stall cycle.
REQ-020 Data read (address 2): returns {24'b0, rx_buf}; side effect clears rx_rdy.
REQ-021 Status read (address 3): side effect clears rx_ovr.
REQ-022 Receiver: rxd 2-flop synchronized; states IDLE, START, DATA, STOP.
REQ-023 IDLE -> START on sampled 0; START rechecks line at BIT_DIV/2, returns to IDLE if 1 (glitch).
REQ-024 DATA samples 8 bits LSB first, one per BIT_DIV clocks at mid-bit.
REQ-025 STOP samples the stop bit; if 1, rx_buf <= byte, rx_rdy <= 1, rx_ovr <= 1 if rx_rdy was already 1; if 0 (framing error) discard byte; return to IDLE.
REQ-026 Simultaneous byte completion and clearing data read: the set wins (rx_rdy = 1, rx_buf = new byte).
REQ-027 Transmitter: states IDLE, BITS; tx_rdy = 1 only in IDLE.
REQ-028 Write to address 2 while tx_rdy = 1 loads the frame {1, outbus[7:0], 0} and starts sending; while tx_rdy = 0 the write is ignored.
REQ-029 Each of the 10 transmitted bits lasts exactly BIT_DIV clocks; tx_rdy rises the cycle after the stop bit ends.

Reset
REQ-030 rst asynchronously sets: leds = 0, timer = 0, rx_rdy = 0, rx_ovr = 0, rx_buf = 0, txd = 1, tx_rdy = 1, both FSMs IDLE, all dividers and synchronizers cleared (synchronizers to idle value 1 for rxd).
REQ-031 rst mid-frame aborts rx/tx immediately; no partial byte is delivered.

Structure
REQ-032 Shared package holds address constants (IO_TIMER = 0, IO_SWI = 1, IO_UDATA = 2, IO_USTAT = 3), status-bit indices and FSM state encodings.
REQ-033 The receiver shall be the sub-module uart_rx (ports clk, rst, rxd, done, data); transmitter and timer stay in io_unit.

Verification
REQ-034 CLK_HZ = 1000000, BAUD = 100000: write 0x55 to address 2 -> txd shows 0,1,0,1,0,1,0,1,0,1, each bit 10 clocks; status bit1 = 0 during the frame, 1 after.
REQ-035 Drive 0xA3 frame on rxd -> status reads 0x1 (tx idle: 0x3); 2-cycle iord at address 2 returns 0xA3 -> status 0x2.
REQ-036 Two frames 0x11 then 0x22 with no read -> data read returns 0x22, status bit2 = 1, cleared after status read.
REQ-037 CLK_HZ = 4000: timer increments every 4 clocks; preload by force to 0xFFFFFFFF -> reads 0 next tick.
REQ-038 rxd low pulse of BIT_DIV/4 clocks -> no byte, rx_rdy stays 0; stop bit = 0 -> byte discarded.
REQ-039 Assert rst during tx bit 4 -> txd = 1 immediately, status = 0x2, leds = 0.
